// File: rtl/alu_pkg.sv
// Shared definitions for the ALU request sequencer.
// Contents:
//   alu_op_e : opcode encodings driven onto the ALU select lines (S)
//   state_e  : sequencer FSM state encoding
package alu_pkg;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_CMP    = 2'b01,
    OP_ADD    = 2'b10,
    OP_ADDSHF = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/settle_timer.sv
// 4-bit down counter that times how long the downstream ALU is allowed to settle.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (count clears to 0)
//   load       : load load_val (has priority over dec)
//   load_val   : value loaded on load
//   dec        : decrement by one; held at zero once zero is reached
//   zero       : count is zero (decoded from the count register)
module settle_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] count;

  // Count register: load, saturating decrement, or hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != 4'd0)) begin
      count <= count - 4'd1;
    end else begin
      count <= count;
    end
  end

  assign zero = (count == 4'd0);

endmodule

// File: rtl/alu_req_sequencer.sv
// Sequences requests into a downstream combinational ALU: registers the
// operands onto X/Y/S, waits SETTLE_CYCLES for the ALU to settle, captures
// F/Cout/Overflow and presents them on a valid/ready response port. Counts
// captured results that overflowed (saturating at 255).
// Ports:
//   clk, rst_n                         : clock, asynchronous active-low reset
//   req_valid/req_ready, req_x/y/op    : request handshake and payload
//   X, Y, S                            : registered drive to the ALU
//   F, Cout, Overflow                  : ALU results
//   rsp_valid/rsp_ready, rsp_f/cout/ovf/op : response handshake and payload
//   ovf_clr, ovf_count                 : overflow counter clear and value
//   busy                               : high whenever the FSM is not IDLE
module alu_req_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [4:0] req_x,
  input  logic [4:0] req_y,
  input  logic [1:0] req_op,
  output logic [4:0] X,
  output logic [4:0] Y,
  output logic [1:0] S,
  input  logic [4:0] F,
  input  logic       Cout,
  input  logic       Overflow,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [4:0] rsp_f,
  output logic       rsp_cout,
  output logic       rsp_ovf,
  output logic [1:0] rsp_op,
  input  logic       ovf_clr,
  output logic [7:0] ovf_count,
  output logic       busy
);

  // Counter is loaded with N-1 so that capture lands exactly N edges after accept.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_e state;
  state_e next_state;
  logic   accept;
  logic   capture;
  logic   tmr_load;
  logic   tmr_dec;
  logic   tmr_zero;

  settle_timer u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (SETTLE_LOAD),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    accept     = 1'b0;
    capture    = 1'b0;
    tmr_load   = 1'b0;
    tmr_dec    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept     = 1'b1;
          tmr_load   = 1'b1;
          next_state = SETTLE;
        end else begin
          next_state = IDLE;
        end
      end
      SETTLE: begin
        if (tmr_zero) begin
          capture    = 1'b1;
          next_state = RESP;
        end else begin
          tmr_dec    = 1'b1;
          next_state = SETTLE;
        end
      end
      RESP: begin
        // A new request is only taken when the current response retires,
        // which gives zero-bubble back-to-back operation.
        req_ready = rsp_ready;
        if (rsp_ready) begin
          if (req_valid) begin
            accept     = 1'b1;
            tmr_load   = 1'b1;
            next_state = SETTLE;
          end else begin
            next_state = IDLE;
          end
        end else begin
          next_state = RESP;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Operand drive, result capture and overflow counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      X         <= 5'd0;
      Y         <= 5'd0;
      S         <= 2'd0;
      rsp_f     <= 5'd0;
      rsp_cout  <= 1'b0;
      rsp_ovf   <= 1'b0;
      rsp_op    <= 2'd0;
      ovf_count <= 8'd0;
    end else begin
      if (accept) begin
        X <= req_x;
        Y <= req_y;
        S <= req_op;
      end
      if (capture) begin
        rsp_f    <= F;
        rsp_cout <= Cout;
        rsp_ovf  <= Overflow;
        rsp_op   <= S;
      end
      // Clear takes priority over a coincident overflowing capture.
      if (ovf_clr) begin
        ovf_count <= 8'd0;
      end else if (capture && Overflow && (ovf_count != 8'd255)) begin
        ovf_count <= ovf_count + 8'd1;
      end else begin
        ovf_count <= ovf_count;
      end
    end
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

endmodule

// File: doc/alu_req_sequencer.md
ALU_REQ_SEQUENCER -- requirements
Module: alu_req_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2: cycles the downstream combinational ALU is given to settle (legal range 1..15).
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port req_valid, input, 1: request present.
REQ-005 SHALL have port req_ready, output, 1: request accepted when req_valid && req_ready at a rising edge.
REQ-006 SHALL have ports req_x, req_y, input, 5 each: operands.
REQ-007 SHALL have port req_op, input, 2: 00 multiply, 01 compare, 10 add, 11 add-and-shift.
REQ-008 SHALL have ports X, Y, output, 5 each, and S, output, 2: registered drive to the ALU.
REQ-009 SHALL have ports F, input, 5, and Cout, Overflow, input, 1 each: ALU results.
REQ-010 SHALL have port rsp_valid, output, 1, and rsp_ready, input, 1: response handshake.
REQ-011 SHALL have ports rsp_f, output, 5; rsp_cout, rsp_ovf, output, 1 each; rsp_op, output, 2: captured result and its opcode.
REQ-012 SHALL have port ovf_clr, input, 1: synchronous clear of ovf_count.
REQ-013 SHALL have port ovf_count, output, 8: count of captured results with Overflow=1.
REQ-014 SHALL have port busy, output, 1: high whenever state is not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, SETTLE, RESP.
REQ-016 IDLE: req_ready=1; on accept, register req_x/req_y/req_op into X/Y/S, load settle counter with SETTLE_CYCLES-1, go SETTLE.
REQ-017 SETTLE: req_ready=0; counter decrements each cycle; at the edge where counter==0, capture F/Cout/Overflow/S into rsp_* and go RESP.
REQ-018 Latency SHALL be exact: accept at edge k -> rsp_valid high after edge k+SETTLE_CYCLES.
REQ-019 RESP: rsp_valid=1, rsp_* held stable until rsp_valid && rsp_ready.
REQ-020 RESP: req_ready SHALL equal rsp_ready; simultaneous response handshake and request accept SHALL load new operands and go SETTLE (zero bubble); response handshake without request goes IDLE.
REQ-021 X/Y/S SHALL hold their last accepted values until the next accept, never changing during SETTLE or RESP.
REQ-022 ovf_count SHALL increment by 1 at each capture with Overflow=1 and saturate at 255.
REQ-023 ovf_clr SHALL set ovf_count to 0 next edge; clear wins over a simultaneous increment.
REQ-024 req_* inputs SHALL be ignored when req_ready=0; rsp_ready SHALL be ignored when rsp_valid=0.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, X=0, Y=0, S=0, rsp_valid=0, rsp_f=0, rsp_cout=0, rsp_ovf=0, rsp_op=0, ovf_count=0, settle counter=0.
REQ-026 Reset mid-SETTLE or mid-RESP SHALL discard the in-flight operation; no response emitted after release.
REQ-027 First accept SHALL be possible at the first rising edge after rst_n deasserts.

Structure
REQ-028 Opcode encodings (OP_MUL, OP_CMP, OP_ADD, OP_ADDSHF) and FSM state encoding SHALL live in a shared package alu_pkg.
REQ-029 Settle counter SHALL be a sub-module settle_timer (load, decrement, zero flag, 4 bits); everything else inline.

Verification (bench stubs the ALU: F=X+Y truncated, Cout=carry, Overflow=signed overflow)
REQ-030 SETTLE_CYCLES=2, req op=10 X=01111 Y=01111, rsp_ready=1 -> rsp_valid exactly 2 cycles after accept, rsp_f=11110, rsp_cout=0, rsp_ovf=1, ovf_count=1.
REQ-031 op=10 X=00010 Y=11010, rsp_ready=0 for 5 cycles -> rsp_f=11100, rsp_ovf=0 held stable, req_ready=0 throughout, busy=1.
REQ-032 Back-to-back: RESP with rsp_ready=1 and req_valid=1 (op=11 X=11010 Y=00010) -> accepted same edge, no IDLE cycle, rsp_op=11 next response.
REQ-033 rst_n pulsed low during SETTLE -> all outputs zero asynchronously, no rsp_valid afterwards, next request completes normally.
REQ-034 256 overflowing requests then one more -> ovf_count=255; ovf_clr coincident with an overflowing capture -> ovf_count=0.
